rns_reverse_scheduler: RTL and testbench
========================================

Name: rns_reverse_scheduler

Overview:
- Multi-cycle, shared-resource version of the {2^N+1, 2^N, 2^N-1} RNS-to-binary reverse converter.
- NREQ requesters each present residue triples. A round-robin arbiter grants one requester at a time.
- A small FSM then sequences a single modulo (2^(2N)-1) adder through the two additions of the conversion. The binary result is returned with the requester id over a valid/ready output.
- The block sits between the RNS arithmetic lanes and binary consumers wherever area matters more than throughput.

Parameters:
- N, 40, residue width; moduli are 2^N+1, 2^N, 2^N-1.
- NREQ, 4, number of requesters, at least 2.
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant/accept, at most one bit high
- req_x1  in  NREQ*(N+1)  residues mod 2^N+1, requester i at bits [i*(N+1) +: N+1]
- req_x2  in  NREQ*N  residues mod 2^N
- req_x3  in  NREQ*N  residues mod 2^N-1
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_data  out  3N  binary value X
- out_id  out  IDW  index of the requester that produced out_data

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - state=IDLE, out_valid=0, out_data=0, out_id=0.
  - RR pointer=NREQ-1, so requester 0 has highest priority after reset.
  - req_ready=0 except through the IDLE grant logic.
- States: IDLE, ADD1, ADD2, DONE.
- IDLE:
  - Grant goes to the first i with req_valid[i], searching from pointer+1 upward with wrap.
  - req_ready[i]=1 only for that i, combinationally; all others 0. No valid requests means no ready.
  - On the handshake, capture x1, x2, x3 and id, set pointer=i, and go to ADD1.
  - req_ready is 0 in every other state.
- Coefficients, computed from the captured operands, 2N bits wide:
  - bx = x1[N]^x1[0].
  - a1 = {bx, x1[N-1:1], bx, x1[N-1:1]}.
  - a2 = {~x2, N ones}.
  - a3 = {x3[0], x3[N-1:1], x3[0], x3[N-1:1]}.
  - t = a1 - x1, truncated to 2N bits (wraps mod 2^(2N)).
- Modulo adder, the only adder instance: s = a+b; s1 = a+b+1.
  - If s1 carries out of bit 2N, result = s1[2N-1:0]; else result = s[2N-1:0].
  - Zero is canonical; the all-ones value is never produced from inputs that sum to 2^(2N)-1.
- ADD1: acc <= a2 +m a3, then go to ADD2.
- ADD2: acc <= acc +m t. Load out_data={result, x2} and out_id, set out_valid=1, then go to DONE.
- DONE:
  - Hold out_data, out_id and out_valid stable while out_ready=0.
  - On out_ready=1: out_valid<=0, go to IDLE.
- Latency: a handshake at edge k gives out_valid=1 after edge k+2.
- Throughput: minimum 4 cycles per conversion; a new grant is possible in the cycle after the out handshake.
- Simultaneous requests: exactly one is granted. Unserved requesters keep valid asserted; starvation-free, worst-case wait is NREQ-1 conversions.
- Request rules:
  - req_valid may drop without a grant.
  - Operands must stay stable only in the handshake cycle.
- Out-of-range x1 (> 2^N): result unspecified, no flag.
- Reset mid-operation in any state: next state IDLE, out_valid=0, any in-flight conversion discarded, pointer reset.

Decomposition:
- Package rns_rev_pkg holds:
  - N default and derived widths W2=2N, W3=3N;
  - state enum {IDLE, ADD1, ADD2, DONE};
  - coefficient helper functions (a1, a2, a3 mapping).
- One sub-module: rns_mod_adder_2n, combinational mod 2^(2N)-1 adder, instantiated once and muxed between (a2,a3) and (acc,t).
- The arbiter stays inline.

Test Plan:
- Zero: req 0 with x1=0, x2=0, x3=0 -> out_valid exactly 3 cycles after the handshake, out_data=0, out_id=0.
- Small value: req 2 with x1=5, x2=5, x3=5 -> out_data=5, out_id=2.
- Upper boundary, X = M-1 where M=(2^80-1)*2^40: x1=2^40, x2=2^40-1, x3=2^40-2 -> out_data=2^120-2^40-1.
- Round-robin: all 4 requesters valid continuously, out_ready=1 -> grants in order 0,1,2,3,0, each 4 cycles apart, out_id matching.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_data/out_id stable, all req_ready=0, then one cycle after out_ready=1 req_ready is granted to the next requester.
- Reset mid-op: rst_n=0 for one edge while in ADD2 -> next cycle state IDLE, out_valid=0; the next grant goes to requester 0 when all are valid.

Source files
------------

// File: rtl/rns_rev_pkg.sv
// Shared widths, FSM state type and coefficient mapping for the
// {2^N+1, 2^N, 2^N-1} RNS-to-binary reverse scheduler.
package rns_rev_pkg;
    localparam int unsigned N  = 40;
    localparam int unsigned W2 = 2 * N;
    localparam int unsigned W3 = 3 * N;

    typedef enum logic [1:0] {IDLE, ADD1, ADD2, DONE} state_e;

    function automatic logic [W2-1:0] coef_a1(input logic [N:0] x1);
        logic bx;
        bx = x1[N] ^ x1[0];
        return {bx, x1[N-1:1], bx, x1[N-1:1]};
    endfunction

    function automatic logic [W2-1:0] coef_a2(input logic [N-1:0] x2);
        return {~x2, {N{1'b1}}};
    endfunction

    function automatic logic [W2-1:0] coef_a3(input logic [N-1:0] x3);
        return {x3[0], x3[N-1:1], x3[0], x3[N-1:1]};
    endfunction

    // Plain 2N-bit wrap; the end-around correction happens in the adder.
    function automatic logic [W2-1:0] coef_t(input logic [N:0] x1);
        return coef_a1(x1) - {{(W2-N-1){1'b0}}, x1};
    endfunction
endpackage

// File: rtl/rns_reverse_scheduler_if.sv
// Requester and consumer handshake bundle of the reverse scheduler.
interface rns_reverse_scheduler_if #(
    parameter int unsigned N    = 40,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*(N+1)-1:0] req_x1;
    logic [NREQ*N-1:0]     req_x2;
    logic [NREQ*N-1:0]     req_x3;
    logic                  out_valid;
    logic                  out_ready;
    logic [3*N-1:0]        out_data;
    logic [IDW-1:0]        out_id;

    modport master (
        output req_valid, req_x1, req_x2, req_x3, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_x1, req_x2, req_x3, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/rns_mod_adder_2n.sv
// Combinational modulo (2^W - 1) adder with canonical zero.
module rns_mod_adder_2n
    import rns_rev_pkg::*;
#(
    parameter int unsigned W = W2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    logic [W:0] s;
    logic [W:0] s1;

    // Selecting a+b+1 on its carry folds 2^W-1 back to zero.
    always_comb begin
        s  = {1'b0, a} + {1'b0, b};
        s1 = s + {{W{1'b0}}, 1'b1};
        y  = s1[W] ? s1[W-1:0] : s[W-1:0];
    end
endmodule

// File: rtl/rns_reverse_scheduler.sv
// Round-robin shared RNS-to-binary converter: one mod (2^2N-1) adder
// sequenced through two additions per granted request.
module rns_reverse_scheduler
    import rns_rev_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input logic                   clk,
    input logic                   rst_n,
    rns_reverse_scheduler_if.slave bus
);
    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [N:0]      x1_q, x1_d, x1_sel;
    logic [N-1:0]    x2_q, x2_d, x2_sel;
    logic [N-1:0]    x3_q, x3_d, x3_sel;
    logic [W2-1:0]   acc_q, acc_d;
    logic            out_valid_q, out_valid_d;
    logic [W3-1:0]   out_data_q, out_data_d;
    logic [IDW-1:0]  out_id_q, out_id_d;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_vld;
    logic [NREQ-1:0] req_ready_c;
    logic [W2-1:0]   add_a, add_b, add_y;

    always_comb begin
        logic [IDW-1:0] cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(ptr_q) + k) % NREQ);
            if (!gnt_vld && bus.req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        x1_sel      = '0;
        x2_sel      = '0;
        x3_sel      = '0;
        req_ready_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_idx) begin
                x1_sel         = bus.req_x1[i*(N+1) +: N+1];
                x2_sel         = bus.req_x2[i*N +: N];
                x3_sel         = bus.req_x3[i*N +: N];
                req_ready_c[i] = (state_q == IDLE) && gnt_vld;
            end
        end
    end

    assign add_a = (state_q == ADD1) ? coef_a2(x2_q) : acc_q;
    assign add_b = (state_q == ADD1) ? coef_a3(x3_q) : coef_t(x1_q);

    rns_mod_adder_2n #(.W(W2)) u_add (
        .a (add_a),
        .b (add_b),
        .y (add_y)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        x3_d        = x3_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        case (state_q)
            IDLE: if (gnt_vld) begin
                x1_d    = x1_sel;
                x2_d    = x2_sel;
                x3_d    = x3_sel;
                id_d    = gnt_idx;
                ptr_d   = gnt_idx;
                state_d = ADD1;
            end
            ADD1: begin
                acc_d   = add_y;
                state_d = ADD2;
            end
            ADD2: begin
                out_data_d  = {add_y, x2_q};
                out_id_d    = id_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: if (bus.out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            x3_q        <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            x3_q        <= x3_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
endmodule

// File: tb/tb_rns_reverse_scheduler.sv
// Directed self-checking bench for rns_reverse_scheduler (N=40, NREQ=4).
module tb_rns_reverse_scheduler;
    localparam int unsigned N    = 40;
    localparam int unsigned NREQ = 4;

    logic   clk = 1'b0;
    logic   rst_n;
    integer total = 0;
    integer bad   = 0;

    always #5 clk = ~clk;

    rns_reverse_scheduler_if #(.N(N), .NREQ(NREQ)) bus ();

    rns_reverse_scheduler #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [N:0] x1,
                           input logic [N-1:0] x2, input logic [N-1:0] x3);
        bus.req_x1[i*(N+1) +: N+1] = x1;
        bus.req_x2[i*N +: N]       = x2;
        bus.req_x3[i*N +: N]       = x3;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        bus.req_valid = '0;
        bus.req_x1    = '0;
        bus.req_x2    = '0;
        bus.req_x3    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
        total++; if (bus.out_id !== '0) begin bad++; $display("FAIL reset_out_id got=%0d exp=0", bus.out_id); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready_idle got=%b exp=0000", bus.req_ready); end
        bus.req_valid = 4'b1111;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL reset_priority got=%b exp=0001", bus.req_ready); end
        bus.req_valid = '0;
        step();
    endtask

    // One isolated conversion from requester i, starting in IDLE.
    task automatic run_single(input string name, input int i, input logic [N:0] x1,
                              input logic [N-1:0] x2, input logic [N-1:0] x3,
                              input logic [3*N-1:0] exp_data);
        logic [3:0] exp_rdy;
        int         lat;
        exp_rdy       = 4'b0001 << i;
        bus.req_valid = '0;
        set_ops(i, x1, x2, x3);
        bus.req_valid[i] = 1'b1;
        #1;
        total++; if (bus.req_ready !== exp_rdy) begin bad++; $display("FAIL %s_ready got=%b exp=%b", name, bus.req_ready, exp_rdy); end
        step();
        bus.req_valid = '0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        total++; if (lat != 3) begin bad++; $display("FAIL %s_latency got=%0d exp=3", name, lat); end
        total++; if (bus.out_data !== exp_data) begin bad++; $display("FAIL %s_data got=%0h exp=%0h", name, bus.out_data, exp_data); end
        total++; if (bus.out_id !== 2'(i)) begin bad++; $display("FAIL %s_id got=%0d exp=%0d", name, bus.out_id, i); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL %s_valid_drop got=%b exp=0", name, bus.out_valid); end
    endtask

    task automatic test_zero;
        run_single("zero", 0, '0, '0, '0, '0);
    endtask

    task automatic test_small;
        run_single("small", 2, 41'd5, 40'd5, 40'd5, 120'd5);
    endtask

    task automatic test_boundary;
        run_single("boundary", 1, 41'h100_0000_0000, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFE,
                   {80'hFFFF_FFFF_FFFF_FFFF_FFFE, 40'hFF_FFFF_FFFF});
    endtask

    task automatic test_pow2;
        run_single("pow2", 3, 41'h100_0000_0000, 40'd0, 40'd1, 120'h100_0000_0000);
    endtask

    task automatic test_round_robin;
        int unsigned ng, no, last, cyc;
        logic [3:0]  er;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_ops(i, 41'(10 + i), 40'(10 + i), 40'(10 + i));
        bus.req_valid = 4'b1111;
        #1;
        ng = 0; no = 0; last = 0; cyc = 0;
        while (no < 5 && cyc < 60) begin
            if (bus.req_ready !== 4'b0000) begin
                er = 4'b0001 << (ng % 4);
                total++; if (bus.req_ready !== er) begin bad++; $display("FAIL rr_grant got=%b exp=%b", bus.req_ready, er); end
                if (ng > 0) begin
                    total++; if (cyc - last != 4) begin bad++; $display("FAIL rr_spacing got=%0d exp=4", cyc - last); end
                end
                last = cyc;
                ng++;
            end
            if (bus.out_valid === 1'b1) begin
                total++; if (bus.out_id !== 2'(no % 4)) begin bad++; $display("FAIL rr_id got=%0d exp=%0d", bus.out_id, no % 4); end
                total++; if (bus.out_data !== 120'(10 + no % 4)) begin bad++; $display("FAIL rr_data got=%0h exp=%0h", bus.out_data, 10 + no % 4); end
                no++;
            end
            if (no < 5) begin
                step();
                cyc++;
            end
        end
        bus.req_valid = '0;
        total++; if (no != 5 || ng != 5) begin bad++; $display("FAIL rr_count got=%0d/%0d exp=5/5", ng, no); end
        step();
    endtask

    task automatic test_backpressure;
        int lat;
        for (int i = 0; i < 4; i++) set_ops(i, 41'(20 + i), 40'(20 + i), 40'(20 + i));
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant got=%b exp=0010", bus.req_ready); end
        step();
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        total++; if (lat != 3) begin bad++; $display("FAIL bp_latency got=%0d exp=3", lat); end
        for (int c = 0; c < 10; c++) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 120'd21 || bus.out_id !== 2'd1 || bus.req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%0h id=%0d rdy=%b exp v=1 d=15 id=1 rdy=0000",
                         c, bus.out_valid, bus.out_data, bus.out_id, bus.req_ready);
            end
            step();
        end
        bus.out_ready = 1'b1;
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL bp_next_grant got=%b exp=0100", bus.req_ready); end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_midop;
        int lat;
        bus.req_valid = 4'b1111;
        #1;
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL mid_grant got=%b exp=0100", bus.req_ready); end
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_data !== '0) begin bad++; $display("FAIL mid_data_clear got=%0h exp=0", bus.out_data); end
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr_reset got=%b exp=0001", bus.req_ready); end
        step();
        bus.req_valid = '0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        total++; if (lat != 3) begin bad++; $display("FAIL mid_latency got=%0d exp=3", lat); end
        total++; if (bus.out_id !== 2'd0) begin bad++; $display("FAIL mid_id got=%0d exp=0", bus.out_id); end
        total++; if (bus.out_data !== 120'd20) begin bad++; $display("FAIL mid_data got=%0h exp=14", bus.out_data); end
        step();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_small();
        test_boundary();
        test_pow2();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
